// File: rtl/gaussian_blur.sv
// ---------------------------------------------------------------------------
// gaussian_blur
//   3x3 Gaussian smoothing ([1 2 1; 2 4 2; 1 2 1], rounded >>4) of an 8-bit
//   grayscale raster frame of WIDTH x HEIGHT pixels. Exactly one output pixel
//   is written per input pixel, in raster order. Border pixels are forced to 0.
//
// Handshake: FIFO-style on both sides. A pixel is consumed in any cycle where
//   in_rd_en=1 (only ever asserted while in_empty=0; in_dout is first-word-
//   fall-through). A pixel is produced in any cycle where out_wr_en=1 (only
//   ever asserted while out_full=0); out_din is valid in that same cycle.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   in_rd_en   pop request to upstream FIFO
//   in_empty   upstream FIFO empty
//   in_dout    upstream pixel
//   out_wr_en  push request to downstream FIFO
//   out_full   downstream FIFO full
//   out_din    blurred pixel
//   dbg_state  current FSM state (0=FILL, 1=RUN, 2=FLUSH)
// ---------------------------------------------------------------------------
module gaussian_blur #(
   parameter int WIDTH  = 720,
   parameter int HEIGHT = 540
) (
   input  logic       clock,
   input  logic       reset,
   output logic       in_rd_en,
   input  logic       in_empty,
   input  logic [7:0] in_dout,
   output logic       out_wr_en,
   input  logic       out_full,
   output logic [7:0] out_din,
   output logic [1:0] dbg_state
);

   localparam int CW    = $clog2(WIDTH);
   localparam int RW    = $clog2(HEIGHT);
   // The incoming pixel is window position 0, so 2*WIDTH+2 stored pixels
   // complete the 2*WIDTH+3 position window.
   localparam int DEPTH = 2*WIDTH + 2;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT-1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
   logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
   logic [7:0]    sr_q [DEPTH];
   logic [7:0]    sr_d [DEPTH];

   logic        in_last, out_last, border;
   logic        in_adv, out_adv, shift_en, rd_go, wr_go;
   logic [7:0]  shift_px;
   logic [11:0] sum;
   logic [7:0]  blur;

   assign in_last  = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
   assign out_last = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
   assign border   = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                     (out_col_q == '0) || (out_col_q == COL_LAST);

   // sr_q[k] holds the pixel consumed k+1 reads ago, so the centre of the
   // window (position WIDTH+1) is sr_q[WIDTH].
   always_comb begin
      sum = {4'd0, in_dout}              + {3'd0, sr_q[0], 1'b0}
          + {4'd0, sr_q[1]}              + {3'd0, sr_q[WIDTH-1], 1'b0}
          + {2'd0, sr_q[WIDTH], 2'b00}   + {3'd0, sr_q[WIDTH+1], 1'b0}
          + {4'd0, sr_q[2*WIDTH-1]}      + {3'd0, sr_q[2*WIDTH], 1'b0}
          + {4'd0, sr_q[2*WIDTH+1]};
   end

   // Max sum 4080 -> max rounded result 255, no saturation needed.
   assign blur = 8'((sum + 12'd8) >> 4);

   assign out_din   = (state_q == S_RUN && !border) ? blur : 8'd0;
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      in_col_d  = in_col_q;
      in_row_d  = in_row_q;
      out_col_d = out_col_q;
      out_row_d = out_row_q;
      sr_d      = sr_q;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      in_adv    = 1'b0;
      out_adv   = 1'b0;
      shift_en  = 1'b0;
      shift_px  = in_dout;

      case (state_q)
         S_FILL: begin
            rd_go    = !in_empty;
            in_adv   = rd_go;
            shift_en = rd_go;
            // Pixel (1,0) is the (WIDTH+1)-th read; after it the centre
            // trails the input by exactly WIDTH+1.
            if (rd_go && in_row_q == RW'(1) && in_col_q == '0) state_d = S_RUN;
         end
         S_RUN: begin
            if (!in_empty && !out_full) begin
               rd_go    = 1'b1;
               wr_go    = 1'b1;
               in_adv   = 1'b1;
               out_adv  = 1'b1;
               shift_en = 1'b1;
               if (in_last) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            wr_go    = !out_full;
            out_adv  = wr_go;
            shift_en = wr_go;
            shift_px = 8'd0;
            if (wr_go && out_last) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase

      if (in_adv) begin
         if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
         end else begin
            in_col_d = in_col_q + CW'(1);
         end
      end

      if (out_adv) begin
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
         end else begin
            out_col_d = out_col_q + CW'(1);
         end
      end

      if (shift_en) begin
         sr_d[0] = shift_px;
         for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
      end

      if (state_q == S_FLUSH && wr_go && out_last) begin
         in_col_d  = '0;
         in_row_d  = '0;
         out_col_d = '0;
         out_row_d = '0;
      end

      // Handshakes stay quiet while reset is held, even if upstream has data.
      in_rd_en  = rd_go && reset;
      out_wr_en = wr_go && reset;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FILL;
         in_col_q  <= '0;
         in_row_q  <= '0;
         out_col_q <= '0;
         out_row_q <= '0;
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= 8'd0;
      end else begin
         state_q   <= state_d;
         in_col_q  <= in_col_d;
         in_row_q  <= in_row_d;
         out_col_q <= out_col_d;
         out_row_q <= out_row_d;
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= sr_d[i];
      end
   end

endmodule

// File: tb/tb_gaussian_blur.sv
// ---------------------------------------------------------------------------
// tb_gaussian_blur
//   Two DUT instances (4x4 "a" and 5x5 "b") fed from queue-modelled FIFOs.
//   Stimulus pushes pixels into the source queue and the reference-model
//   output for every pixel into an expected queue; a per-instance monitor
//   pops and compares on every write.
// ---------------------------------------------------------------------------
module tb_gaussian_blur;

   localparam int ST_FILL  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_FLUSH = 2;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT a: 4x4 ----------------
   logic       a_rd, a_wr;
   logic       a_empty = 1'b1;
   logic       a_full  = 1'b0;
   logic [7:0] a_dout  = 8'd0;
   logic [7:0] a_din;
   logic [1:0] a_st;

   gaussian_blur #(.WIDTH(4), .HEIGHT(4)) dut_a (
      .clock(clock), .reset(reset),
      .in_rd_en(a_rd), .in_empty(a_empty), .in_dout(a_dout),
      .out_wr_en(a_wr), .out_full(a_full), .out_din(a_din),
      .dbg_state(a_st)
   );

   // ---------------- DUT b: 5x5 ----------------
   logic       b_rd, b_wr;
   logic       b_empty = 1'b1;
   logic       b_full  = 1'b0;
   logic [7:0] b_dout  = 8'd0;
   logic [7:0] b_din;
   logic [1:0] b_st;

   gaussian_blur #(.WIDTH(5), .HEIGHT(5)) dut_b (
      .clock(clock), .reset(reset),
      .in_rd_en(b_rd), .in_empty(b_empty), .in_dout(b_dout),
      .out_wr_en(b_wr), .out_full(b_full), .out_din(b_din),
      .dbg_state(b_st)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic [7:0] src_a[$];
   logic [7:0] src_b[$];
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   bit a_rnd = 1'b0, b_rnd = 1'b0, a_hold_full = 1'b0;
   bit a_rd_c = 1'b0, a_wr_c = 1'b0, b_rd_c = 1'b0, b_wr_c = 1'b0;
   logic [7:0] a_din_c, b_din_c;
   int a_st_prev = ST_FILL;
   int a_rds = 0, a_wrs = 0, a_first = -1, a_flushes = 0;
   int b_rds = 0, b_wrs = 0;

   function automatic void chk(input string nm, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   // Weighted 3x3 neighbourhood with weights 4 (centre), 2 (edge), 1 (corner);
   // rounded division by 16; frame border is 0.
   function automatic int blur_at(input int w, input int h, input int img[],
                                  input int r, input int c);
      int s;
      if (r == 0 || r == h-1 || c == 0 || c == w-1) return 0;
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[(r+dr)*w + (c+dc)];
      return (s + 8) / 16;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_a(input int img[]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src_a.push_back(8'(img[r*4+c]));
            exp_a.push_back(8'(blur_at(4, 4, img, r, c)));
         end
   endtask

   task automatic load_b(input int img[]);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            src_b.push_back(8'(img[r*5+c]));
            exp_b.push_back(8'(blur_at(5, 5, img, r, c)));
         end
   endtask

   task automatic wait_a(input int budget);
      int n = 0;
      while ((exp_a.size() != 0 || src_a.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      repeat (4) @(negedge clock);
      #2;
      chk("a_drain_left", exp_a.size(), 0);
      chk("a_idle_state", int'(a_st), ST_FILL);
   endtask

   task automatic wait_b(input int budget);
      int n = 0;
      while ((exp_b.size() != 0 || src_b.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      repeat (4) @(negedge clock);
      #2;
      chk("b_drain_left", exp_b.size(), 0);
      chk("b_idle_state", int'(b_st), ST_FILL);
   endtask

   task automatic zero_a_counts();
      a_rds = 0; a_wrs = 0; a_first = -1; a_flushes = 0;
   endtask

   // ---------------- FIFO models + monitors ----------------
   // Inputs change on the falling edge; handshakes are captured 1 time unit
   // later and committed at the next falling edge (after the rising edge
   // that actually performed them).
   always @(negedge clock) begin
      if (a_rd_c) begin
         if (src_a.size() > 0) void'(src_a.pop_front());
         a_rds++;
      end
      if (a_wr_c) begin
         if (exp_a.size() == 0) chk("a_unexpected_write", int'(a_din_c), -1);
         else chk("a_pixel", int'(a_din_c), int'(exp_a.pop_front()));
         a_wrs++;
         if (a_wrs == 1) a_first = a_rds;
      end
      a_empty = (src_a.size() == 0) || (a_rnd && $urandom_range(0, 2) == 0);
      a_dout  = (src_a.size() > 0) ? src_a[0] : 8'd0;
      a_full  = a_hold_full || (a_rnd && $urandom_range(0, 3) == 0);
      #1;
      a_rd_c  = a_rd;
      a_wr_c  = a_wr;
      a_din_c = a_din;
      if (a_rd) chk("a_rd_while_empty", int'(a_empty), 0);
      if (a_wr) chk("a_wr_while_full", int'(a_full), 0);
      if (a_hold_full && int'(a_st) == ST_RUN) chk("a_rd_under_full", int'(a_rd), 0);
      if (int'(a_st) == ST_FLUSH && a_st_prev != ST_FLUSH) a_flushes++;
      a_st_prev = int'(a_st);
   end

   always @(negedge clock) begin
      if (b_rd_c) begin
         if (src_b.size() > 0) void'(src_b.pop_front());
         b_rds++;
      end
      if (b_wr_c) begin
         if (exp_b.size() == 0) chk("b_unexpected_write", int'(b_din_c), -1);
         else chk("b_pixel", int'(b_din_c), int'(exp_b.pop_front()));
         b_wrs++;
      end
      b_empty = (src_b.size() == 0) || (b_rnd && $urandom_range(0, 2) == 0);
      b_dout  = (src_b.size() > 0) ? src_b[0] : 8'd0;
      b_full  = b_rnd && $urandom_range(0, 3) == 0;
      #1;
      b_rd_c  = b_rd;
      b_wr_c  = b_wr;
      b_din_c = b_din;
      if (b_rd) chk("b_rd_while_empty", int'(b_empty), 0);
      if (b_wr) chk("b_wr_while_full", int'(b_full), 0);
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int img4[];
      int img5[];
      int n;
      int w0, r0;
      img4 = new[16];
      img5 = new[25];

      // Reset values
      #1;
      chk("rst_a_rd", int'(a_rd), 0);
      chk("rst_a_wr", int'(a_wr), 0);
      chk("rst_a_din", int'(a_din), 0);
      chk("rst_a_state", int'(a_st), ST_FILL);
      chk("rst_b_wr", int'(b_wr), 0);
      chk("rst_b_state", int'(b_st), ST_FILL);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Constant 100, no stalls: interior 100, first write on 6th read
      zero_a_counts();
      foreach (img4[i]) img4[i] = 100;
      load_a(img4);
      wait_a(200);
      chk("t1_first_write_read", a_first, 6);
      chk("t1_writes", a_wrs, 16);
      chk("t1_reads", a_rds, 16);

      // Single impulse of 160 at (2,2) on 5x5
      foreach (img5[i]) img5[i] = 0;
      img5[2*5+2] = 160;
      chk("t2_model_centre", blur_at(5, 5, img5, 2, 2), 40);
      chk("t2_model_edge", blur_at(5, 5, img5, 1, 2), 20);
      chk("t2_model_corner", blur_at(5, 5, img5, 3, 3), 10);
      b_wrs = 0;
      load_b(img5);
      wait_b(300);
      chk("t2_writes", b_wrs, 25);

      // All 255: no overflow in the interior
      zero_a_counts();
      foreach (img4[i]) img4[i] = 255;
      load_a(img4);
      wait_a(200);
      chk("t3_writes", a_wrs, 16);

      // Ramp with random empty/full and a 10-cycle forced full mid-RUN
      zero_a_counts();
      foreach (img4[i]) img4[i] = i * 16;
      a_rnd = 1'b1;
      load_a(img4);
      n = 0;
      while (!(int'(a_st) == ST_RUN && a_wrs >= 2) && n < 500) begin
         @(negedge clock);
         #2;
         n++;
      end
      chk("t4_reached_run", int'(int'(a_st) == ST_RUN && a_wrs >= 2), 1);
      a_hold_full = 1'b1;
      @(negedge clock);
      #2;
      w0 = a_wrs;
      r0 = a_rds;
      repeat (9) @(negedge clock);
      #2;
      chk("t4_no_write_stalled", a_wrs, w0);
      chk("t4_no_read_stalled", a_rds, r0);
      a_hold_full = 1'b0;
      wait_a(1000);
      a_rnd = 1'b0;
      chk("t4_writes", a_wrs, 16);

      // Two back-to-back frames: 100s then 50s
      zero_a_counts();
      foreach (img4[i]) img4[i] = 100;
      load_a(img4);
      foreach (img4[i]) img4[i] = 50;
      load_a(img4);
      wait_a(400);
      chk("t5_writes", a_wrs, 32);
      chk("t5_reads", a_rds, 32);
      chk("t5_flush_passes", a_flushes, 2);

      // Reset after 7 reads, then a clean constant-100 frame
      zero_a_counts();
      foreach (img4[i]) img4[i] = 100;
      load_a(img4);
      n = 0;
      while (a_rds < 7 && n < 200) begin
         @(negedge clock);
         #2;
         n++;
      end
      chk("t6_reads_before_reset", a_rds, 7);
      reset = 1'b0;
      #1;
      chk("t6_rst_wr", int'(a_wr), 0);
      chk("t6_rst_rd", int'(a_rd), 0);
      chk("t6_rst_din", int'(a_din), 0);
      chk("t6_rst_state", int'(a_st), ST_FILL);
      src_a.delete();
      exp_a.delete();
      a_rd_c = 1'b0;
      a_wr_c = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      zero_a_counts();
      load_a(img4);
      wait_a(200);
      chk("t6_writes_after_reset", a_wrs, 16);
      chk("t6_first_write_read", a_first, 6);

      // Random frames with random stalls on both instances
      a_rnd = 1'b1;
      b_rnd = 1'b1;
      for (int f = 0; f < 3; f++) begin
         foreach (img4[i]) img4[i] = int'($urandom_range(0, 255));
         load_a(img4);
      end
      for (int f = 0; f < 2; f++) begin
         foreach (img5[i]) img5[i] = int'($urandom_range(0, 255));
         load_b(img5);
      end
      wait_a(3000);
      wait_b(3000);
      a_rnd = 1'b0;
      b_rnd = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      bad++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gaussian_blur.md
Name: gaussian_blur

Overview:
- 3x3 Gaussian smoothing stage for 8-bit grayscale pixel streams, one raster frame of WIDTH x HEIGHT at a time.
- Sits between the grayscale converter's output FIFO and the Sobel stage's input FIFO; suppresses noise before gradient computation.
- FIFO-read / FIFO-write handshakes on both sides. Emits exactly one output pixel per input pixel, in raster order.

Parameters:
WIDTH, 720, pixels per row (>=3)
HEIGHT, 540, rows per frame (>=3)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_rd_en  output  1  pop request to upstream FIFO
in_empty  input  1  upstream FIFO empty
in_dout  input  8  upstream pixel; first-word-fall-through, valid whenever in_empty=0
out_wr_en  output  1  push request to downstream FIFO
out_full  input  1  downstream FIFO full
out_din  output  8  blurred pixel

Behaviour:
- Kernel [1 2 1; 2 4 2; 1 2 1].
  - Sum is 12 bits unsigned (max 4080).
  - Result = (sum + 8) >> 4, i.e. round-half-up. Max result is 255, so no saturation logic is needed.
- Window storage: shift register of 2*WIDTH+3 pixels, zeroed on reset.
  - Each consumed pixel shifts in at the head.
  - Window taps are positions {0,1,2, W,W+1,W+2, 2W,2W+1,2W+2}, combined with the incoming pixel.
- Input counters in_col/in_row track the pixel being consumed.
- Output counters out_col/out_row track the window centre.
  - The centre lags the input by WIDTH+1 pixels.
  - Counter widths are $clog2 of WIDTH/HEIGHT.
- Border rule: if out_row==0, out_row==HEIGHT-1, out_col==0 or out_col==WIDTH-1, then out_din=0. Otherwise out_din is the kernel result.
- FSM:
  - FILL (reset state):
    - in_rd_en = !in_empty. No writes.
    - Consumes the first WIDTH+1 pixels, then goes to RUN.
  - RUN:
    - in_rd_en = out_wr_en = !in_empty && !out_full, in the same cycle.
    - out_din is computed combinationally from the window including in_dout.
    - After the last pixel of the frame is consumed (in_row=HEIGHT-1, in_col=WIDTH-1), goes to FLUSH.
  - FLUSH:
    - in_rd_en=0. out_wr_en = !out_full.
    - Shifts in zero on each write.
    - After WIDTH+1 writes (all border, value 0), clears counters and returns to FILL.
- Per-frame invariant: exactly WIDTH*HEIGHT reads and WIDTH*HEIGHT writes, in raster order.
- Back-to-back frames: the next frame's pixels wait in the upstream FIFO until FLUSH completes. No frame-boundary bleed, because row/column borders force 0.
- Backpressure:
  - out_full=1 stalls RUN/FLUSH with no read, no write and no state change.
  - FILL keeps reading regardless of out_full.
- Empty upstream: in_empty=1 stalls FILL/RUN with no write. FLUSH proceeds independently of in_empty.
- Never asserts in_rd_en while in_empty=1. Never asserts out_wr_en while out_full=1.
- Reset values (reset low, asynchronous):
  - state=FILL; all counters 0; shift register 0.
  - in_rd_en=0, out_wr_en=0, out_din=0.
  - Mid-frame reset discards the partial frame; the first pixel after release is treated as (0,0).
- Latency: the output for centre (r,c) is written in the same cycle input (r,c) shifted by +WIDTH+1 in raster order is read, or during FLUSH for the final WIDTH+1 centres.

Test Plan:
- WIDTH=4, HEIGHT=4, all pixels 100, no stalls -> 16 outputs: (1,1),(1,2),(2,1),(2,2)=100, other 12 =0. First write occurs on the 6th read.
- WIDTH=5, HEIGHT=5, single 160 at (2,2), others 0 -> (2,2)=40; (1,2),(2,1),(2,3),(3,2)=20; (1,1),(1,3),(3,1),(3,3)=10; rest 0.
- WIDTH=4, HEIGHT=4, all pixels 255 -> interior 255 (no overflow), border 0.
- Ramp image with out_full held high 10 cycles mid-RUN and in_empty toggled randomly -> no reads/writes while stalled; output stream bit-identical to the unstalled run; 16 writes total.
- Two back-to-back 4x4 frames (100s then 50s) -> 32 outputs; frame 2 interior all 50 with no frame-1 contamination; FSM passes FILL->RUN->FLUSH twice.
- Reset pulsed low after 7 reads of a frame -> outputs drop to 0 immediately and state=FILL; a subsequent full constant-100 frame yields the correct 16 outputs.
